// File: rtl/clk_pkg.sv
// Shared types and constants for the BCD time-of-day core.
// The hour helpers work directly on packed BCD hour values 00..23.
package clk_pkg;

    typedef struct packed {
        logic [3:0] h_tens;
        logic [3:0] h_ones;
        logic [3:0] m_tens;
        logic [3:0] m_ones;
        logic [3:0] s_tens;
        logic [3:0] s_ones;
    } bcd_time_t;

    typedef enum logic {
        ST_IDLE,
        ST_RING
    } alarm_state_t;

    localparam int         HOUR_MOD     = 24;
    localparam int         MINSEC_MOD   = 60;
    localparam logic [7:0] ALARM_RST_HH = 8'h06;
    localparam logic [7:0] ALARM_RST_MM = 8'h00;

    // BCD ordering matches numeric ordering, so a plain compare suffices
    function automatic logic hour_is_pm(input logic [7:0] h);
        return h >= 8'h12;
    endfunction

    function automatic logic [7:0] hour_to_12h(input logic [7:0] h);
        logic [4:0] b;
        logic [4:0] r;
        b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
        if (b == 5'd0)
            r = 5'd12;
        else if (b > 5'd12)
            r = b - 5'd12;
        else
            r = b;
        if (r >= 5'd10)
            return {4'd1, 4'(r - 5'd10)};
        return {4'd0, 4'(r)};
    endfunction

endpackage

// File: rtl/alarm_clock_if.sv
// Control inputs and display outputs of the alarm clock core.
// The core uses the slave view; whatever drives the buttons uses master.
interface alarm_clock_if;
    logic       mode_24;
    logic       set_alarm;
    logic       adv_hr;
    logic       adv_min;
    logic       alarm_en;
    logic       alarm_ack;
    logic [3:0] h_tens;
    logic [3:0] h_ones;
    logic [3:0] m_tens;
    logic [3:0] m_ones;
    logic [3:0] s_tens;
    logic [3:0] s_ones;
    logic       pm;
    logic       alarm;
    logic       tick;

    modport master (
        output mode_24, set_alarm, adv_hr, adv_min, alarm_en, alarm_ack,
        input  h_tens, h_ones, m_tens, m_ones, s_tens, s_ones, pm, alarm, tick
    );

    modport slave (
        input  mode_24, set_alarm, adv_hr, adv_min, alarm_en, alarm_ack,
        output h_tens, h_ones, m_tens, m_ones, s_tens, s_ones, pm, alarm, tick
    );
endinterface

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter advancing by 0, 1 or 2 per cycle.
// nxt_o exposes the value the register takes at the coming edge.
module bcd_mod_cnt #(
    parameter int         MOD     = 60,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic [1:0] step_i,
    output logic [7:0] nxt_o,
    output logic       carry_o
);

    localparam logic [7:0] MAX_VAL = 8'((((MOD - 1) / 10) << 4) | ((MOD - 1) % 10));

    logic [7:0] val_q, val_d, once;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == MAX_VAL)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        once    = bcd_inc(val_q);
        val_d   = val_q;
        carry_o = 1'b0;
        if (clr_i) begin
            val_d = 8'h00;
        end else if (step_i == 2'd1) begin
            val_d   = once;
            carry_o = (val_q == MAX_VAL);
        end else if (step_i == 2'd2) begin
            val_d   = bcd_inc(once);
            carry_o = (val_q == MAX_VAL) || (once == MAX_VAL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            val_q <= RST_VAL;
        else
            val_q <= val_d;
    end

    assign nxt_o = rst ? RST_VAL : val_d;

endmodule

// File: rtl/alarm_clock.sv
// 12/24-hour BCD time-of-day core with prescaler, manual set and one alarm.
// Time is kept in 24-hour BCD; the registered display is built from next-state values.
module alarm_clock
    import clk_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int ALARM_LEN_S = 60
) (
    input  logic         clk,
    input  logic         rst,
    alarm_clock_if.slave bus
);

    localparam int               CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]       RING_LAST = 8'(ALARM_LEN_S - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;
    logic             edit_min, edit_hr, alm_min, alm_hr;
    logic [7:0]       ss_nxt, mm_nxt, hh_nxt, am_nxt, ah_nxt;
    logic             ss_carry, mm_carry;
    logic             hh_carry_unused, am_carry_unused, ah_carry_unused;
    logic [1:0]       hh_step;
    logic             trig;
    alarm_state_t     state_q, state_d;
    logic [7:0]       ring_q, ring_d;
    logic             alarm_q;
    bcd_time_t        disp_q, disp_d;
    logic             pm_q, pm_d;
    logic [7:0]       src_hh;

    assign edit_min = bus.adv_min & ~bus.set_alarm;
    assign edit_hr  = bus.adv_hr  & ~bus.set_alarm;
    assign alm_min  = bus.adv_min &  bus.set_alarm;
    assign alm_hr   = bus.adv_hr  &  bus.set_alarm;

    // A minute edit restarts the second so the new minute begins cleanly
    assign cnt_d = (edit_min | tick_q) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_MAX);
        end
    end

    bcd_mod_cnt #(.MOD(MINSEC_MOD), .RST_VAL(8'h00)) u_ss (
        .clk(clk), .rst(rst), .clr_i(edit_min), .step_i({1'b0, tick_q}),
        .nxt_o(ss_nxt), .carry_o(ss_carry)
    );

    bcd_mod_cnt #(.MOD(MINSEC_MOD), .RST_VAL(8'h00)) u_mm (
        .clk(clk), .rst(rst), .clr_i(1'b0), .step_i({1'b0, edit_min | ss_carry}),
        .nxt_o(mm_nxt), .carry_o(mm_carry)
    );

    // Only a tick-driven minute wrap carries into the hour
    assign hh_step = {1'b0, edit_hr} + {1'b0, mm_carry & ~edit_min};

    bcd_mod_cnt #(.MOD(HOUR_MOD), .RST_VAL(8'h00)) u_hh (
        .clk(clk), .rst(rst), .clr_i(1'b0), .step_i(hh_step),
        .nxt_o(hh_nxt), .carry_o(hh_carry_unused)
    );

    bcd_mod_cnt #(.MOD(MINSEC_MOD), .RST_VAL(ALARM_RST_MM)) u_am (
        .clk(clk), .rst(rst), .clr_i(1'b0), .step_i({1'b0, alm_min}),
        .nxt_o(am_nxt), .carry_o(am_carry_unused)
    );

    bcd_mod_cnt #(.MOD(HOUR_MOD), .RST_VAL(ALARM_RST_HH)) u_ah (
        .clk(clk), .rst(rst), .clr_i(1'b0), .step_i({1'b0, alm_hr}),
        .nxt_o(ah_nxt), .carry_o(ah_carry_unused)
    );

    // ss_carry implies a tick rolled seconds to 00 without a manual minute edit
    assign trig = tick_q & ss_carry & bus.alarm_en & (mm_nxt == am_nxt) & (hh_nxt == ah_nxt);

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_RING;
                    ring_d  = 8'd0;
                end
            end
            ST_RING: begin
                if (bus.alarm_ack || !bus.alarm_en) begin
                    state_d = ST_IDLE;
                end else if (tick_q) begin
                    if (ring_q == RING_LAST)
                        state_d = ST_IDLE;
                    else
                        ring_d = ring_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ring_q  <= 8'd0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            alarm_q <= (state_d == ST_RING);
        end
    end

    always_comb begin
        disp_d                        = '0;
        src_hh                        = hh_nxt;
        {disp_d.m_tens, disp_d.m_ones} = mm_nxt;
        {disp_d.s_tens, disp_d.s_ones} = ss_nxt;
        if (bus.set_alarm) begin
            src_hh                         = ah_nxt;
            {disp_d.m_tens, disp_d.m_ones} = am_nxt;
            {disp_d.s_tens, disp_d.s_ones} = 8'h00;
        end
        pm_d                           = hour_is_pm(src_hh);
        {disp_d.h_tens, disp_d.h_ones} = bus.mode_24 ? src_hh : hour_to_12h(src_hh);
    end

    // Display register follows the counters' next values, which already honour rst
    always_ff @(posedge clk) begin
        disp_q <= disp_d;
        pm_q   <= pm_d;
    end

    assign bus.h_tens = disp_q.h_tens;
    assign bus.h_ones = disp_q.h_ones;
    assign bus.m_tens = disp_q.m_tens;
    assign bus.m_ones = disp_q.m_ones;
    assign bus.s_tens = disp_q.s_tens;
    assign bus.s_ones = disp_q.s_ones;
    assign bus.pm     = pm_q;
    assign bus.alarm  = alarm_q;
    assign bus.tick   = tick_q;

endmodule

// File: tb/tb_alarm_clock.sv
// Scoreboard bench for alarm_clock: a behavioural integer model predicts every cycle,
// plus directed checks at the interesting points of each scenario.
module tb_alarm_clock;

    localparam int TICK_DIV    = 4;
    localparam int ALARM_LEN_S = 3;

    typedef struct packed {
        logic [23:0] digits;
        logic        pm;
        logic        alarm;
        logic        tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    alarm_clock_if bus();

    alarm_clock #(.TICK_DIV(TICK_DIV), .ALARM_LEN_S(ALARM_LEN_S)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int m_cnt, m_hh, m_mm, m_ss, m_ah, m_am, m_ring;
    bit m_ringing;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] disp();
        return {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones};
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Predict the state after the coming edge from the inputs currently applied
    task automatic model_step();
        exp_t e;
        bit   tk, em, eh, hc;
        int   dh, dm, ds;
        tk = (m_cnt == TICK_DIV - 1);
        if (rst) begin
            m_cnt = 0; m_hh = 0; m_mm = 0; m_ss = 0;
            m_ah = 6; m_am = 0; m_ringing = 0; m_ring = 0;
        end else begin
            em = bus.adv_min && !bus.set_alarm;
            eh = bus.adv_hr && !bus.set_alarm;
            hc = 0;
            m_cnt = (em || tk) ? 0 : m_cnt + 1;
            if (em) begin
                m_ss = 0;
                m_mm = (m_mm + 1) % 60;
            end else if (tk) begin
                m_ss++;
                if (m_ss == 60) begin
                    m_ss = 0;
                    m_mm++;
                    if (m_mm == 60) begin
                        m_mm = 0;
                        hc = 1;
                    end
                end
            end
            m_hh = (m_hh + int'(eh) + int'(hc)) % 24;
            if (bus.set_alarm) begin
                m_am = (m_am + int'(bus.adv_min)) % 60;
                m_ah = (m_ah + int'(bus.adv_hr)) % 24;
            end
            if (!m_ringing) begin
                if (tk && !em && m_ss == 0 && bus.alarm_en && m_hh == m_ah && m_mm == m_am) begin
                    m_ringing = 1;
                    m_ring = 0;
                end
            end else if (bus.alarm_ack || !bus.alarm_en) begin
                m_ringing = 0;
            end else if (tk) begin
                m_ring++;
                if (m_ring == ALARM_LEN_S) m_ringing = 0;
            end
        end
        dh = bus.set_alarm ? m_ah : m_hh;
        dm = bus.set_alarm ? m_am : m_mm;
        ds = bus.set_alarm ? 0 : m_ss;
        e.pm = (dh >= 12);
        if (!bus.mode_24) dh = (dh == 0) ? 12 : ((dh > 12) ? dh - 12 : dh);
        e.digits = {bcd2(dh), bcd2(dm), bcd2(ds)};
        e.alarm  = m_ringing;
        e.tick   = (m_cnt == TICK_DIV - 1);
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("digits", 32'(disp()), 32'(e.digits));
        check_eq("pm", 32'(bus.pm), 32'(e.pm));
        check_eq("alarm", 32'(bus.alarm), 32'(e.alarm));
        check_eq("tick", 32'(bus.tick), 32'(e.tick));
    endtask

    task automatic pulse_min();
        bus.adv_min = 1'b1;
        cyc();
        bus.adv_min = 1'b0;
    endtask

    task automatic pulse_hr();
        bus.adv_hr = 1'b1;
        cyc();
        bus.adv_hr = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.alarm_ack = 1'b1;
        cyc();
        bus.alarm_ack = 1'b0;
    endtask

    task automatic set_alarm_min_plus1();
        bus.set_alarm = 1'b1;
        pulse_min();
        bus.set_alarm = 1'b0;
    endtask

    task automatic wait_alarm(input int budget);
        int i = 0;
        while (!bus.alarm && i < budget) begin
            cyc();
            i++;
        end
        check_eq("ring_wait", 32'(bus.alarm), 32'd1);
    endtask

    task automatic wait_pre_roll(input int budget);
        int i = 0;
        while (!(bus.tick && bus.s_tens == 4'd5 && bus.s_ones == 4'd9) && i < budget) begin
            cyc();
            i++;
        end
        check_eq("preroll_wait", 32'(bus.tick), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        bus.mode_24 = 1'b1;
        bus.set_alarm = 1'b0;
        bus.adv_hr = 1'b0;
        bus.adv_min = 1'b0;
        bus.alarm_en = 1'b0;
        bus.alarm_ack = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        check_eq("reset_digits", 32'(disp()), 32'h000000);
        check_eq("reset_alarm", 32'(bus.alarm), 32'd0);
        check_eq("reset_tick", 32'(bus.tick), 32'd0);

        // Rollover: load 23:59:00, run 60 seconds
        repeat (23) pulse_hr();
        repeat (59) pulse_min();
        check_eq("load_2359", 32'(disp()), 32'h235900);
        repeat (60 * TICK_DIV) cyc();
        check_eq("rollover_24h", 32'(disp()), 32'h000000);
        bus.mode_24 = 1'b0;
        cyc();
        check_eq("rollover_12h", 32'(disp()), 32'h120000);
        check_eq("rollover_pm", 32'(bus.pm), 32'd0);
        t = 0;
        repeat (2 * TICK_DIV) begin
            cyc();
            t += int'(bus.tick);
        end
        check_eq("tick_period", 32'(t), 32'd2);

        // Mode mapping
        bus.mode_24 = 1'b1;
        repeat (13) pulse_hr();
        repeat (5) pulse_min();
        bus.mode_24 = 1'b0;
        cyc();
        check_eq("map_13_12h", 32'(disp() >> 8), 32'h0105);
        check_eq("map_13_pm12", 32'(bus.pm), 32'd1);
        bus.mode_24 = 1'b1;
        cyc();
        check_eq("map_13_24h", 32'(disp() >> 8), 32'h1305);
        check_eq("map_13_pm24", 32'(bus.pm), 32'd1);
        repeat (23) pulse_hr();
        repeat (55) pulse_min();
        bus.mode_24 = 1'b0;
        cyc();
        check_eq("map_12_12h", 32'(disp() >> 8), 32'h1200);
        check_eq("map_12_pm", 32'(bus.pm), 32'd1);
        bus.mode_24 = 1'b1;

        // Manual set: minute wrap without hour carry, and minute edit against a tick
        repeat (59) pulse_min();
        repeat (6) cyc();
        pulse_min();
        check_eq("min_wrap", 32'(disp()), 32'h120000);
        t = 0;
        while (!bus.tick && t < 2 * TICK_DIV) begin
            cyc();
            t++;
        end
        check_eq("tick_wait", 32'(bus.tick), 32'd1);
        pulse_min();
        check_eq("min_vs_tick", 32'(disp()), 32'h120100);

        // Alarm trigger and auto-stop
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.set_alarm = 1'b1;
        cyc();
        check_eq("alarm_rst_time", 32'(disp()), 32'h060000);
        repeat (18) pulse_hr();
        pulse_min();
        check_eq("alarm_0001", 32'(disp()), 32'h000100);
        bus.set_alarm = 1'b0;
        repeat (60) pulse_min();
        bus.alarm_en = 1'b1;
        repeat (60 * TICK_DIV - 1) cyc();
        check_eq("pre_trigger", 32'(bus.alarm), 32'd0);
        cyc();
        check_eq("trigger", 32'(bus.alarm), 32'd1);
        check_eq("trigger_time", 32'(disp()), 32'h000100);
        repeat (ALARM_LEN_S * TICK_DIV - 1) cyc();
        check_eq("ring_hold", 32'(bus.alarm), 32'd1);
        cyc();
        check_eq("auto_stop", 32'(bus.alarm), 32'd0);

        // Manual landing on the alarm time does not ring
        set_alarm_min_plus1();
        pulse_min();
        repeat (3) cyc();
        check_eq("manual_no_ring", 32'(bus.alarm), 32'd0);

        // Ack coincident with trigger is ignored, later ack stops
        set_alarm_min_plus1();
        wait_pre_roll(70 * TICK_DIV);
        bus.alarm_ack = 1'b1;
        cyc();
        bus.alarm_ack = 1'b0;
        check_eq("ack_at_trigger", 32'(bus.alarm), 32'd1);
        check_eq("ack_trig_time", 32'(disp()), 32'h000300);
        pulse_ack();
        check_eq("ack_stop", 32'(bus.alarm), 32'd0);

        // Disable while ringing
        set_alarm_min_plus1();
        wait_alarm(70 * TICK_DIV);
        bus.alarm_en = 1'b0;
        cyc();
        check_eq("disable_stop", 32'(bus.alarm), 32'd0);
        bus.alarm_en = 1'b1;

        // Reset mid-ring
        set_alarm_min_plus1();
        wait_alarm(70 * TICK_DIV);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_eq("rst_ring_alarm", 32'(bus.alarm), 32'd0);
        check_eq("rst_ring_time", 32'(disp()), 32'h000000);
        bus.set_alarm = 1'b1;
        cyc();
        check_eq("rst_ring_atime", 32'(disp()), 32'h060000);
        check_eq("rst_presc_1", 32'(bus.tick), 32'd0);
        cyc();
        check_eq("rst_presc_2", 32'(bus.tick), 32'd0);
        cyc();
        check_eq("rst_presc_3", 32'(bus.tick), 32'd1);
        bus.set_alarm = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
